resource_devirtualiser: RTL and testbench

Receive-side counterpart of the resource virtualiser in the memory-share datapath. One physical resource is time-shared by `VIRTUAL_NUM` virtual users, and it returns one result per slot. This block collects those serial results back into `VIRTUAL_NUM` parallel virtual output ports and presents each completed round through a valid/ready handshake. It sits directly after the physical resource and is driven by the same schedule strobe as the virtualiser.

---
 rtl/memshare_virt_pkg.sv | 20 ++
 rtl/devirt_slot_delay.sv | 31 +++
 rtl/resource_devirtualiser.sv | 150 +++++++++++++++
 tb/tb_resource_devirtualiser.sv | 136 +++++++++++++
 4 files changed

// File: rtl/memshare_virt_pkg.sv
// Shared definitions for the memory-share virtualiser/devirtualiser pair:
// default dimensions and the one-hot slot rotate helper.
package memshare_virt_pkg;

  localparam int VIRTUAL_NUM_DEF   = 2;
  localparam int PORT_BITWIDTH_DEF = 5;
  localparam int SLOT_IDX_W        = $clog2(VIRTUAL_NUM_DEF);
  localparam int ONEHOT_MAX        = 64;

  // Rotate a one-hot vector left within its lowest n bits; bit n-1 wraps to bit 0.
  function automatic logic [ONEHOT_MAX-1:0] onehot_rotl(
    input logic [ONEHOT_MAX-1:0] v,
    input int                    n
  );
    logic [ONEHOT_MAX-1:0] mask;
    mask = (ONEHOT_MAX'(1) << n) - ONEHOT_MAX'(1);
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

endpackage

// File: rtl/devirt_slot_delay.sv
// Fixed-depth shift register carrying {strobe, one-hot slot} so that the
// capture controls line up with the physical resource output.
module devirt_slot_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      always_ff @(posedge sys_clk) begin
        if (!rstn) stage_reg[gi] <= '0;
        else       stage_reg[gi] <= din;
      end
    end else begin : g_next
      always_ff @(posedge sys_clk) begin
        if (!rstn) stage_reg[gi] <= '0;
        else       stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/resource_devirtualiser.sv
// Collects serial per-slot results of a time-shared resource into parallel
// virtual ports. Define MEMSHARE_DEVIRT_DBUF_EN to add a shadow round register.
module resource_devirtualiser
  import memshare_virt_pkg::*;
#(
  parameter int VIRTUAL_NUM   = VIRTUAL_NUM_DEF,
  parameter int PORT_BITWIDTH = PORT_BITWIDTH_DEF,
  parameter int PHY_LATENCY   = 1
) (
  input  logic                               sys_clk,
  input  logic                               rstn,
  input  logic                               virSched_en_i,
  input  logic [PORT_BITWIDTH-1:0]           phyDout_i,
  output logic [VIRTUAL_NUM*PORT_BITWIDTH-1:0] virDout_o,
  output logic                               virDout_valid_o,
  input  logic                               virDout_ready_i,
  output logic                               overflow_o
);

  localparam int RW = VIRTUAL_NUM * PORT_BITWIDTH;

  logic [VIRTUAL_NUM-1:0] sched_cnt_reg;
  logic [VIRTUAL_NUM-1:0] sched_cnt_next;
  logic [ONEHOT_MAX-1:0]  sched_rot;
  logic                   unused_rot_hi;

  assign sched_rot      = onehot_rotl(ONEHOT_MAX'(sched_cnt_reg), VIRTUAL_NUM);
  assign unused_rot_hi  = |sched_rot[ONEHOT_MAX-1:VIRTUAL_NUM];
  assign sched_cnt_next = virSched_en_i ? sched_rot[VIRTUAL_NUM-1:0]
                                        : VIRTUAL_NUM'(1);

  always_ff @(posedge sys_clk) begin
    if (!rstn) sched_cnt_reg <= VIRTUAL_NUM'(1);
    else       sched_cnt_reg <= sched_cnt_next;
  end

  logic                   cap_en;
  logic [VIRTUAL_NUM-1:0] cap_slot;

  devirt_slot_delay #(
    .DEPTH (PHY_LATENCY),
    .WIDTH (VIRTUAL_NUM + 1)
  ) u_slot_delay (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .din     ({virSched_en_i, sched_cnt_reg}),
    .dout    ({cap_en, cap_slot})
  );

  // The last slot never needs storing: it goes straight into the round.
  logic [PORT_BITWIDTH-1:0] collect_reg [VIRTUAL_NUM-1];
  logic [RW-1:0]            round;

  for (genvar gi = 0; gi < VIRTUAL_NUM; gi++) begin : g_slot
    if (gi == VIRTUAL_NUM - 1) begin : g_last
      assign round[gi*PORT_BITWIDTH +: PORT_BITWIDTH] = phyDout_i;
    end else begin : g_store
      always_ff @(posedge sys_clk) begin
        if (!rstn)                        collect_reg[gi] <= '0;
        else if (cap_en && cap_slot[gi])  collect_reg[gi] <= phyDout_i;
      end
      assign round[gi*PORT_BITWIDTH +: PORT_BITWIDTH] = collect_reg[gi];
    end
  end

  logic complete;
  logic handshake;

  assign complete  = cap_en & cap_slot[VIRTUAL_NUM-1];
  assign handshake = virDout_valid_o & virDout_ready_i;

  logic [RW-1:0] dout_reg, dout_next;
  logic          valid_reg, valid_next;
  logic          ovf_reg, ovf_next;

`ifdef MEMSHARE_DEVIRT_DBUF_EN
  logic [RW-1:0] shadow_reg, shadow_next;
  logic          shadow_valid_reg, shadow_valid_next;

  always_comb begin
    dout_next         = dout_reg;
    valid_next        = valid_reg;
    ovf_next          = ovf_reg;
    shadow_next       = shadow_reg;
    shadow_valid_next = shadow_valid_reg;
    if (handshake) begin
      if (shadow_valid_reg) begin
        dout_next         = shadow_reg;
        shadow_valid_next = complete;
        if (complete) shadow_next = round;
      end else if (complete) begin
        dout_next = round;
      end else begin
        valid_next = 1'b0;
      end
    end else if (complete) begin
      if (!valid_reg) begin
        dout_next  = round;
        valid_next = 1'b1;
      end else if (!shadow_valid_reg) begin
        shadow_next       = round;
        shadow_valid_next = 1'b1;
      end else begin
        ovf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      shadow_reg       <= '0;
      shadow_valid_reg <= 1'b0;
    end else begin
      shadow_reg       <= shadow_next;
      shadow_valid_reg <= shadow_valid_next;
    end
  end
`else
  always_comb begin
    dout_next  = dout_reg;
    valid_next = valid_reg;
    ovf_next   = ovf_reg;
    if (complete && (!valid_reg || virDout_ready_i)) begin
      dout_next  = round;
      valid_next = 1'b1;
    end else if (complete) begin
      ovf_next = 1'b1;
    end else if (handshake) begin
      valid_next = 1'b0;
    end
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      dout_reg  <= '0;
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      dout_reg  <= dout_next;
      valid_reg <= valid_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign virDout_o       = dout_reg;
  assign virDout_valid_o = valid_reg;
  assign overflow_o      = ovf_reg;

endmodule

// File: tb/tb_resource_devirtualiser.sv
// Directed self-checking bench for resource_devirtualiser (N=2, W=5, L=1).
module tb_resource_devirtualiser;

  logic       sys_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       virSched_en_i = 1'b0;
  logic [4:0] phyDout_i = '0;
  logic [9:0] virDout_o;
  logic       virDout_valid_o;
  logic       virDout_ready_i = 1'b1;
  logic       overflow_o;

  int total = 0;
  int bad   = 0;

`ifdef MEMSHARE_DEVIRT_DBUF_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  always #5 sys_clk = ~sys_clk;

  resource_devirtualiser #(
    .VIRTUAL_NUM   (2),
    .PORT_BITWIDTH (5),
    .PHY_LATENCY   (1)
  ) dut (
    .sys_clk         (sys_clk),
    .rstn            (rstn),
    .virSched_en_i   (virSched_en_i),
    .phyDout_i       (phyDout_i),
    .virDout_o       (virDout_o),
    .virDout_valid_o (virDout_valid_o),
    .virDout_ready_i (virDout_ready_i),
    .overflow_o      (overflow_o)
  );

  // Drive this cycle's inputs, then move to just after the next rising edge.
  task automatic cyc(input logic en, input logic [4:0] d);
    virSched_en_i = en;
    phyDout_i     = d;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    // reset
    rstn = 1'b0;
    cyc(0, 0); cyc(0, 0); cyc(0, 0);
    chk("rst_dout",  32'(virDout_o),       32'h0);
    chk("rst_valid", 32'(virDout_valid_o), 32'h0);
    chk("rst_ovf",   32'(overflow_o),      32'h0);
    rstn = 1'b1;
    cyc(0, 0);

    // basic round
    virDout_ready_i = 1'b1;
    cyc(1, 5'h00); cyc(1, 5'h0A); cyc(0, 5'h15);
    chk("basic_valid", 32'(virDout_valid_o), 32'h1);
    chk("basic_dout",  32'(virDout_o),       32'h2AA);
    cyc(0, 0);
    chk("basic_drop",  32'(virDout_valid_o), 32'h0);

    // back-to-back rounds
    cyc(1, 0); cyc(1, 1); cyc(1, 2);
    chk("b2b_v1",   32'(virDout_valid_o), 32'h1);
    chk("b2b_d1",   32'(virDout_o),       32'h041);
    cyc(1, 3);
    chk("b2b_gap1", 32'(virDout_valid_o), 32'h0);
    cyc(1, 4);
    chk("b2b_v2",   32'(virDout_valid_o), 32'h1);
    chk("b2b_d2",   32'(virDout_o),       32'h083);
    cyc(1, 5);
    chk("b2b_gap2", 32'(virDout_valid_o), 32'h0);
    cyc(0, 6);
    chk("b2b_v3",   32'(virDout_valid_o), 32'h1);
    chk("b2b_d3",   32'(virDout_o),       32'h0C5);
    cyc(0, 0);
    chk("b2b_end",  32'(virDout_valid_o), 32'h0);
    chk("b2b_ovf",  32'(overflow_o),      32'h0);

    // partial-round abort, then a full round
    cyc(1, 0); cyc(0, 9); cyc(0, 0);
    chk("abort_v1", 32'(virDout_valid_o), 32'h0);
    cyc(0, 0);
    chk("abort_v2", 32'(virDout_valid_o), 32'h0);
    cyc(1, 0); cyc(1, 7); cyc(0, 8);
    chk("abort_rv", 32'(virDout_valid_o), 32'h1);
    chk("abort_rd", 32'(virDout_o),       32'h107);
    chk("abort_ovf", 32'(overflow_o),     32'h0);
    cyc(0, 0);

    // backpressure: two rounds with ready low
    virDout_ready_i = 1'b0;
    cyc(1, 0); cyc(1, 5'h11); cyc(1, 5'h12);
    chk("bp_v1",   32'(virDout_valid_o), 32'h1);
    chk("bp_d1",   32'(virDout_o),       32'h251);
    cyc(1, 5'h13); cyc(0, 5'h14);
    chk("bp_hold_v", 32'(virDout_valid_o), 32'h1);
    chk("bp_hold_d", 32'(virDout_o),       32'h251);
    chk("bp_ovf",    32'(overflow_o),      32'(!DBUF));
    virDout_ready_i = 1'b1;
    cyc(0, 0);
    chk("bp_v2", 32'(virDout_valid_o), 32'(DBUF));
    if (DBUF) chk("bp_d2", 32'(virDout_o), 32'h293);
    cyc(0, 0);
    chk("bp_v3",     32'(virDout_valid_o), 32'h0);
    chk("ovf_sticky", 32'(overflow_o),     32'(!DBUF));

    // reset in mid-round
    cyc(1, 0); cyc(1, 5'h1F);
    rstn = 1'b0;
    cyc(0, 0);
    chk("mrst_dout",  32'(virDout_o),       32'h0);
    chk("mrst_valid", 32'(virDout_valid_o), 32'h0);
    chk("mrst_ovf",   32'(overflow_o),      32'h0);
    rstn = 1'b1;
    cyc(1, 0); cyc(1, 3); cyc(0, 4);
    chk("mrst_rv", 32'(virDout_valid_o), 32'h1);
    chk("mrst_rd", 32'(virDout_o),       32'h083);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
